// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared encodings and control bundle for the multi-cycle sequencer
package mc_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] WB_DM  = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic OP1_PC  = 1'b0;
    localparam logic OP1_RS1 = 1'b1;
    localparam logic OP2_RS2 = 1'b0;
    localparam logic OP2_IMM = 1'b1;

    localparam logic [4:0] BR_NONE = 5'b11111;

    typedef enum logic [2:0] {
        CLS_R       = 3'd0,
        CLS_IALU    = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_JAL     = 3'd5,
        CLS_ILLEGAL = 3'd6
    } instr_cls_e;

    typedef struct packed {
        instr_cls_e cls;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [2:0] alu_func3;
        logic       alu_subsra;
        logic       op1_sel;
        logic       op2_sel;
        logic [1:0] wb_sel;
        logic [4:0] br_op;
    } ctrl_t;

    function automatic instr_cls_e classify(input logic [6:0] opcode);
        case (opcode)
            OP_R:      return CLS_R;
            OP_IALU:   return CLS_IALU;
            OP_LOAD:   return CLS_LOAD;
            OP_STORE:  return CLS_STORE;
            OP_BRANCH: return CLS_BRANCH;
            OP_JAL:    return CLS_JAL;
            default:   return CLS_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/mc_sequencer_if.sv
// rtl/mc_sequencer_if.sv - instruction/memory handshake and control outputs of the sequencer
interface mc_sequencer_if;
    logic [31:0] instr;
    logic        branch_taken;
    logic        dm_ready;

    logic        ir_load;
    logic        pc_write;
    logic        pc_sel;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rf_wenable;
    logic        dm_req;
    logic        dm_wenable;
    logic [2:0]  alu_func3;
    logic        alu_subsra;
    logic        op1_sel;
    logic        op2_sel;
    logic [1:0]  wb_sel;
    logic [4:0]  br_op;
    logic [2:0]  state;
    logic        halted;
    logic        illegal;
    logic        timeout;
    logic [31:0] retired;

    modport master (
        output instr, branch_taken, dm_ready,
        input  ir_load, pc_write, pc_sel, rs1, rs2, rd, rf_wenable, dm_req, dm_wenable,
        input  alu_func3, alu_subsra, op1_sel, op2_sel, wb_sel, br_op,
        input  state, halted, illegal, timeout, retired
    );

    modport slave (
        input  instr, branch_taken, dm_ready,
        output ir_load, pc_write, pc_sel, rs1, rs2, rd, rf_wenable, dm_req, dm_wenable,
        output alu_func3, alu_subsra, op1_sel, op2_sel, wb_sel, br_op,
        output state, halted, illegal, timeout, retired
    );
endinterface

// File: rtl/mc_decoder.sv
// rtl/mc_decoder.sv - purely combinational map from instruction word to control bundle
module mc_decoder
    import mc_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_t       ctrl
);

    instr_cls_e cls;
    logic [2:0] funct3;
    logic       unused_bits;

    assign funct3      = instr[14:12];
    assign unused_bits = ^{instr[31], instr[29:25]};

    always_comb begin
        cls             = classify(instr[6:0]);
        ctrl            = '0;
        ctrl.cls        = cls;
        ctrl.rs1        = instr[19:15];
        ctrl.rs2        = instr[24:20];
        ctrl.rd         = instr[11:7];
        ctrl.alu_func3  = 3'b000;
        ctrl.alu_subsra = 1'b0;
        ctrl.op1_sel    = OP1_RS1;
        ctrl.op2_sel    = OP2_IMM;
        ctrl.wb_sel     = WB_ALU;
        ctrl.br_op      = BR_NONE;
        // address/target computations use the ALU as a plain adder
        case (cls)
            CLS_R: begin
                ctrl.alu_func3  = funct3;
                ctrl.alu_subsra = instr[30];
                ctrl.op2_sel    = OP2_RS2;
            end
            CLS_IALU: begin
                ctrl.alu_func3  = funct3;
                ctrl.alu_subsra = (funct3 == 3'b101) ? instr[30] : 1'b0;
            end
            CLS_LOAD: begin
                ctrl.wb_sel = WB_DM;
            end
            CLS_BRANCH: begin
                ctrl.op1_sel = OP1_PC;
                ctrl.br_op   = {2'b00, funct3};
            end
            CLS_JAL: begin
                ctrl.op1_sel = OP1_PC;
                ctrl.wb_sel  = WB_PC4;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/mc_sequencer.sv
// rtl/mc_sequencer.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with wait and retire counters
module mc_sequencer
    import mc_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic          clk,
    input  logic          reset,
    mc_sequencer_if.slave bus
);

    localparam int              WW        = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0]   WAIT_LAST = WW'(MAX_WAIT - 1);

    state_e        state_q;
    ctrl_t         ctrl_q;
    ctrl_t         ctrl_dec;
    logic [WW-1:0] wait_q;
    logic [31:0]   retired_q;
    logic          illegal_q;
    logic          timeout_q;

    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_jal;
    logic ir_load;
    logic pc_write;
    logic pc_sel;
    logic rf_wenable;
    logic dm_req;
    logic dm_wenable;

    mc_decoder u_decoder (
        .instr (bus.instr),
        .ctrl  (ctrl_dec)
    );

    assign is_load   = (ctrl_q.cls == CLS_LOAD);
    assign is_store  = (ctrl_q.cls == CLS_STORE);
    assign is_branch = (ctrl_q.cls == CLS_BRANCH);
    assign is_jal    = (ctrl_q.cls == CLS_JAL);

    // Strobes depend only on registered state/fields plus the two handshake inputs;
    // reset masks them so an abandoned instruction never commits.
    always_comb begin
        ir_load    = 1'b0;
        pc_write   = 1'b0;
        pc_sel     = 1'b0;
        rf_wenable = 1'b0;
        dm_req     = 1'b0;
        dm_wenable = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_FETCH: ir_load = 1'b1;
                ST_EXEC: begin
                    if (is_branch) begin
                        pc_write = 1'b1;
                        pc_sel   = bus.branch_taken;
                    end
                end
                ST_MEM: begin
                    dm_req = 1'b1;
                    if (bus.dm_ready && is_store) begin
                        dm_wenable = 1'b1;
                        pc_write   = 1'b1;
                    end
                end
                ST_WB: begin
                    pc_write   = 1'b1;
                    pc_sel     = is_jal;
                    rf_wenable = (ctrl_q.rd != 5'd0);
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            ctrl_q    <= '0;
            wait_q    <= '0;
            retired_q <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (pc_write) begin
                retired_q <= retired_q + 32'd1;
            end
            case (state_q)
                ST_FETCH: state_q <= ST_DECODE;
                ST_DECODE: begin
                    ctrl_q <= ctrl_dec;
                    if (ctrl_dec.cls == CLS_ILLEGAL) begin
                        state_q   <= ST_HALT;
                        illegal_q <= 1'b1;
                    end else begin
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (ctrl_q.cls)
                        CLS_R, CLS_IALU, CLS_JAL: state_q <= ST_WB;
                        CLS_LOAD, CLS_STORE: begin
                            state_q <= ST_MEM;
                            wait_q  <= '0;
                        end
                        default: state_q <= ST_FETCH;
                    endcase
                end
                ST_MEM: begin
                    if (bus.dm_ready) begin
                        wait_q  <= '0;
                        state_q <= is_load ? ST_WB : ST_FETCH;
                    end else if (wait_q == WAIT_LAST) begin
                        state_q   <= ST_HALT;
                        timeout_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                ST_WB:   state_q <= ST_FETCH;
                ST_HALT: state_q <= ST_HALT;
                default: state_q <= ST_HALT;
            endcase
        end
    end

    assign bus.ir_load    = ir_load;
    assign bus.pc_write   = pc_write;
    assign bus.pc_sel     = pc_sel;
    assign bus.rf_wenable = rf_wenable;
    assign bus.dm_req     = dm_req;
    assign bus.dm_wenable = dm_wenable;
    assign bus.rs1        = ctrl_q.rs1;
    assign bus.rs2        = ctrl_q.rs2;
    assign bus.rd         = ctrl_q.rd;
    assign bus.alu_func3  = ctrl_q.alu_func3;
    assign bus.alu_subsra = ctrl_q.alu_subsra;
    assign bus.op1_sel    = ctrl_q.op1_sel;
    assign bus.op2_sel    = ctrl_q.op2_sel;
    assign bus.wb_sel     = ctrl_q.wb_sel;
    assign bus.br_op      = ctrl_q.br_op;
    assign bus.state      = state_q;
    assign bus.halted     = (state_q == ST_HALT);
    assign bus.illegal    = illegal_q;
    assign bus.timeout    = timeout_q;
    assign bus.retired    = retired_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// tb/tb_mc_sequencer.sv - table, directed and random checks of mc_sequencer against a trace model
module tb_mc_sequencer;

    localparam int MAX_WAIT = 15;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mc_sequencer_if bus();

    mc_sequencer #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_ret = '0;

    typedef struct {
        logic [31:0] ins;
        bit          taken;
        int          waits;
        int          exp_len;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        bus.instr        = $urandom;
        bus.branch_taken = 1'b1;
        bus.dm_ready     = 1'b1;
        @(negedge clk);
        chk("rst_cycle_strobes",
            64'({bus.ir_load, bus.dm_req, bus.dm_wenable, bus.rf_wenable, bus.pc_write}), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_state_flags",
            64'({bus.state, bus.halted, bus.illegal, bus.timeout, bus.retired}), 64'd0);
        chk("rst_fields",
            64'({bus.rs1, bus.rs2, bus.rd, bus.br_op, bus.alu_subsra, bus.op1_sel, bus.op2_sel,
                 bus.wb_sel, bus.alu_func3, bus.ir_load, bus.dm_req, bus.dm_wenable,
                 bus.rf_wenable, bus.pc_write}), 64'd0);
        @(posedge clk); #1;
        reset     = 1'b0;
        model_ret = '0;
    endtask

    // Expected behaviour is derived per cycle from instruction class and latency rules.
    task automatic run_instr(input logic [31:0] ins, input bit taken, input int waits,
                             input int abort_at, output int pcw_at);
        logic [6:0]  op;
        logic [2:0]  f3;
        bit          is_r, is_i, is_ld, is_st, is_br, is_jal, legal, tmo, in_mem;
        bit          ir, req, wen, rfw, pcw, psel, hlt, ill, tf, writes_rf;
        int          n, mem_end, mem_len;
        logic [2:0]  st;
        logic [12:0] exp_v, act_v;
        logic [25:0] exp_f, act_f;
        op      = ins[6:0];
        f3      = ins[14:12];
        is_r    = (op == 7'b0110011);
        is_i    = (op == 7'b0010011);
        is_ld   = (op == 7'b0000011);
        is_st   = (op == 7'b0100011);
        is_br   = (op == 7'b1100011);
        is_jal  = (op == 7'b1101111);
        legal   = is_r || is_i || is_ld || is_st || is_br || is_jal;
        tmo     = (is_ld || is_st) && (waits >= MAX_WAIT);
        mem_end = 3 + waits;
        mem_len = tmo ? MAX_WAIT : waits + 1;
        writes_rf = is_r || is_i || is_ld || is_jal;
        if (!legal)      n = 5;
        else if (tmo)    n = 3 + MAX_WAIT + 3;
        else if (is_br)  n = 3;
        else if (is_st)  n = 4 + waits;
        else if (is_ld)  n = 5 + waits;
        else             n = 4;
        pcw_at = -1;
        for (int c = 0; c < n; c++) begin
            if (c == abort_at) begin
                do_reset();
                return;
            end
            in_mem           = (is_ld || is_st) && (c >= 3) && (c < 3 + mem_len);
            bus.instr        = ins;
            bus.branch_taken = (is_br && c == 2) ? taken : 1'($urandom);
            bus.dm_ready     = in_mem ? (!tmo && c == mem_end) : 1'($urandom);
            hlt  = (!legal && c >= 2) || (tmo && c >= 3 + MAX_WAIT);
            ill  = !legal && c >= 2;
            tf   = tmo && c >= 3 + MAX_WAIT;
            ir   = (c == 0);
            req  = in_mem;
            wen  = in_mem && is_st && !tmo && c == mem_end;
            pcw  = legal && !tmo && c == n - 1;
            psel = is_br ? taken : is_jal;
            rfw  = pcw && writes_rf && (ins[11:7] != 5'd0);
            if (hlt)         st = 3'd5;
            else if (c < 3)  st = 3'(c);
            else if (in_mem) st = 3'd3;
            else             st = 3'd4;
            @(negedge clk);
            exp_v = {st, ir, req, wen, rfw, pcw, pcw ? psel : 1'b0, hlt, ill, tf};
            act_v = {bus.state, bus.ir_load, bus.dm_req, bus.dm_wenable, bus.rf_wenable,
                     bus.pc_write, pcw ? bus.pc_sel : 1'b0, bus.halted, bus.illegal, bus.timeout};
            chk($sformatf("ctl cyc%0d ins=%h", c, ins), 64'(act_v), 64'(exp_v));
            chk($sformatf("retired cyc%0d ins=%h", c, ins), 64'(bus.retired), 64'(model_ret));
            if (legal && c >= 2) begin
                exp_f = {ins[19:15], ins[24:20], ins[11:7],
                         is_br ? {2'b00, f3} : 5'h1f,
                         (is_r || (is_i && f3 == 3'b101)) ? ins[30] : 1'b0,
                         !(is_br || is_jal), !is_r,
                         (is_r || is_i) ? f3 : 3'b000};
                act_f = {bus.rs1, bus.rs2, bus.rd, bus.br_op, bus.alu_subsra, bus.op1_sel,
                         bus.op2_sel, (is_r || is_i) ? bus.alu_func3 : 3'b000};
                chk($sformatf("fields cyc%0d ins=%h", c, ins), 64'(act_f), 64'(exp_f));
            end
            if (pcw && writes_rf) begin
                chk($sformatf("wb_sel ins=%h", ins), 64'(bus.wb_sel),
                    64'(is_ld ? 2'b00 : (is_jal ? 2'b10 : 2'b01)));
            end
            if (bus.pc_write && pcw_at < 0) pcw_at = c;
            if (pcw) model_ret = model_ret + 32'd1;
            @(posedge clk); #1;
        end
    endtask

    logic [6:0] ops[6];
    int         pcw_at;
    logic [31:0] rins;

    initial begin
        reset            = 1'b1;
        bus.instr        = '0;
        bus.branch_taken = 1'b0;
        bus.dm_ready     = 1'b0;
        @(posedge clk); #1;
        do_reset();

        tbl[0]  = '{32'h002081B3, 1'b0, 0,  4};   // ADD x3,x1,x2
        tbl[1]  = '{32'h0000A283, 1'b0, 2,  7};   // LW x5,0(x1), two waits
        tbl[2]  = '{32'h00208063, 1'b1, 0,  3};   // BEQ taken
        tbl[3]  = '{32'h00208063, 1'b0, 0,  3};   // BEQ not taken
        tbl[4]  = '{32'h0020A023, 1'b0, 0,  4};   // SW, ready at once
        tbl[5]  = '{32'h0020A023, 1'b0, 3,  7};   // SW, three waits
        tbl[6]  = '{32'h00100013, 1'b0, 0,  4};   // ADDI x0,x0,1
        tbl[7]  = '{32'h000000EF, 1'b0, 0,  4};   // JAL x1
        tbl[8]  = '{32'h4030D213, 1'b0, 0,  4};   // SRAI x4,x1,3
        tbl[9]  = '{32'h40208333, 1'b0, 0,  4};   // SUB x6,x1,x2
        tbl[10] = '{32'h00209063, 1'b1, 0,  3};   // BNE taken
        tbl[11] = '{32'h0020A023, 1'b0, 14, 18};  // SW, last wait before timeout
        for (int i = 0; i < 12; i++) begin
            run_instr(tbl[i].ins, tbl[i].taken, tbl[i].waits, -1, pcw_at);
            chk($sformatf("latency vec%0d", i), 64'(pcw_at + 1), 64'(tbl[i].exp_len));
        end
        chk("retired after table", 64'(bus.retired), 64'd12);

        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111};
        for (int i = 0; i < 40; i++) begin
            rins      = $urandom;
            rins[6:0] = ops[$urandom_range(0, 5)];
            run_instr(rins, 1'($urandom), $urandom_range(0, 5), -1, pcw_at);
        end

        run_instr(32'h0000007F, 1'b0, 0, -1, pcw_at);
        chk("illegal no pc_write", 64'(pcw_at < 0), 64'd1);
        do_reset();
        run_instr(32'h002081B3, 1'b0, 0, -1, pcw_at);

        run_instr(32'h0020A023, 1'b0, MAX_WAIT, -1, pcw_at);
        chk("timeout store no pc_write", 64'(pcw_at < 0), 64'd1);
        do_reset();
        run_instr(32'h0000A283, 1'b0, 40, -1, pcw_at);
        do_reset();

        run_instr(32'h00100013, 1'b0, 0, -1, pcw_at);
        run_instr(32'h0020A023, 1'b0, 2, 4, pcw_at);
        run_instr(32'h000000EF, 1'b0, 0, -1, pcw_at);
        chk("retired after abort", 64'(bus.retired), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_sequencer.md
MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 Parameter MAX_WAIT, default 15, max cycles the MEM state waits for dm_ready before timeout.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 instr  input  32  instruction word from instruction memory at current PC.
REQ-005 branch_taken  input  1  branch comparator result for the current branch.
REQ-006 dm_ready  input  1  data memory completes the access this cycle.
REQ-007 ir_load  output  1  latches instr into the instruction register.
REQ-008 pc_write  output  1  PC update strobe; pc_sel  output  1  (0 = PC+4, 1 = ALU result).
REQ-009 rs1, rs2, rd  output  5 each  register file addresses.
REQ-010 rf_wenable  output  1  register write strobe; dm_req  output  1  memory request; dm_wenable  output  1  store strobe.
REQ-011 alu_func3  output  3; alu_subsra  output  1; op1_sel  output  1  (1 = rs1, 0 = PC); op2_sel  output  1  (1 = imm, 0 = rs2).
REQ-012 wb_sel  output  2  (00 = DM, 01 = ALU, 10 = PC+4); br_op  output  5.
REQ-013 state  output  3; halted  output  1; illegal  output  1; timeout  output  1; retired  output  32.

Function
REQ-014 The FSM SHALL have states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
REQ-015 FETCH SHALL assert ir_load for exactly one cycle and then go to DECODE.
REQ-016 DECODE SHALL register all decoded fields from instr. The registered fields SHALL stay stable until the next DECODE.
REQ-017 Recognised opcodes: 0110011 (R), 0010011 (I-ALU), 0000011 (load), 0100011 (store), 1100011 (branch), 1101111 (JAL).
REQ-018 Any other opcode in DECODE SHALL go to HALT and set illegal=1.
REQ-019 alu_subsra SHALL equal instr[30] for R-type and for I-ALU with funct3=101; it SHALL be 0 otherwise.
REQ-020 br_op SHALL equal {2'b00, funct3} for branches and 5'b11111 otherwise.
REQ-021 Branch and JAL SHALL use op1_sel=0 and op2_sel=1. R-type SHALL use op1_sel=1 and op2_sel=0. All other classes SHALL use op1_sel=1 and op2_sel=1.
REQ-022 EXEC transitions:
  - R, I-ALU, JAL: go to WB.
  - Load, store: go to MEM.
  - Branch: assert pc_write with pc_sel=branch_taken, then go to FETCH.
REQ-023 MEM SHALL hold dm_req=1 until dm_ready=1.
REQ-024 For a store, dm_wenable SHALL be 1 only in the cycle in which dm_ready=1.
REQ-025 When the MEM access completes:
  - Load: go to WB.
  - Store: assert pc_write with pc_sel=0, then go to FETCH.
REQ-026 A wait counter SHALL count MEM cycles with dm_ready=0. Reaching MAX_WAIT SHALL go to HALT with timeout=1, and no write SHALL occur.
REQ-027 WB SHALL assert rf_wenable for one cycle, except that rf_wenable SHALL be forced to 0 when rd=0.
REQ-028 wb_sel in WB SHALL be: DM for load, ALU for R and I-ALU, PC+4 for JAL.
REQ-029 WB SHALL assert pc_write with pc_sel=1 for JAL and pc_sel=0 otherwise, then go to FETCH.
REQ-030 pc_write SHALL pulse exactly once per completed instruction, and retired SHALL increment in that same cycle.
REQ-031 retired SHALL wrap from 0xFFFFFFFF to 0.
REQ-032 Instruction latency (cycles): branch 3, R / I-ALU / JAL 4, store 4+waits, load 5+waits.
REQ-033 All strobes (ir_load, pc_write, rf_wenable, dm_req, dm_wenable) SHALL be 0 outside their defined states.
REQ-034 HALT SHALL be sticky until reset, with halted=1 and all strobes 0.
REQ-035 Outputs SHALL be registered or decoded from the registered state only; no combinational path from instr to any strobe.

Reset
REQ-036 reset=1 SHALL, at the next edge, set state=FETCH, all outputs and registered fields to 0, retired=0, the wait counter to 0, and clear illegal, timeout and halted.
REQ-037 reset asserted mid-instruction, including in MEM or HALT, SHALL abandon the instruction with no pc_write, rf_wenable or dm_wenable in that cycle.
REQ-038 reset SHALL take priority over all other events in the same cycle.

Structure
REQ-039 The shared package mc_pkg SHALL hold the state encoding, opcode constants, wb_sel and operand-select encodings, and the BR_NONE=5'b11111 constant.
REQ-040 A combinational sub-module mc_decoder SHALL map instr to a control bundle. mc_sequencer SHALL register that bundle in DECODE and own the FSM, wait counter and retired counter.

Verification
REQ-041 ADD x3,x1,x2 (0x002081B3): ir_load in cycle 0, rf_wenable=1 and rd=3, wb_sel=01 in cycle 3, pc_write with pc_sel=0 in cycle 3, retired=1.
REQ-042 LW x5,0(x1) with dm_ready low for 2 cycles: dm_req high for 3 cycles, rf_wenable with wb_sel=00 one cycle later, 7 cycles total.
REQ-043 BEQ with branch_taken=1, then branch_taken=0: pc_write in cycle 2 with pc_sel=1, then pc_sel=0; rf_wenable and dm_wenable never asserted.
REQ-044 Store with dm_ready held 0, MAX_WAIT=15: HALT after 15 MEM cycles, timeout=1, dm_wenable never 1, outputs frozen until reset.
REQ-045 Illegal opcode 0x0000007F: HALT after DECODE with illegal=1; a reset pulse in HALT returns to FETCH with all flags 0.
REQ-046 ADDI x0,x0,1, plus a reset pulse during MEM: rf_wenable stays 0 for rd=0; on reset no strobe fires and retired=0.
